repeated_sub_divider: RTL and testbench

//  Sequential unsigned divider by repeated subtraction: the inverse of the multiplier, sharing its scheme.

---
 rtl/div_pkg.sv | 17 +
 rtl/repeated_sub_divider_if.sv | 39 +++
 rtl/div_control_path.sv | 101 ++++++++++
 rtl/repeated_sub_divider.sv | 102 ++++++++++
 tb/tb_repeated_sub_divider.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: default operand
// width and the FSM state encoding used by the control path.
// Optional feature macro: DIV_CYCLE_COUNT_EN (adds the cycle_cnt counter/port).
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDA   = 3'd1,
    LDB   = 3'd2,
    CHECK = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/repeated_sub_divider_if.sv
// Handshake and operand/result bus of the repeated-subtraction divider.
// master = requester (drives start/data), slave = divider.
// Optional feature macro: DIV_CYCLE_COUNT_EN adds cycle_cnt to the bus.
interface repeated_sub_divider_if #(
  parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cycle_cnt;

  modport master (
    output start, data,
    input  busy, done, div_by_zero, quotient, remainder, cycle_cnt
  );

  modport slave (
    input  start, data,
    output busy, done, div_by_zero, quotient, remainder, cycle_cnt
  );
`else
  modport master (
    output start, data,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, data,
    output busy, done, div_by_zero, quotient, remainder
  );
`endif

endinterface

// File: rtl/div_control_path.sv
// Control FSM of the repeated-subtraction divider.
// Sequences IDLE -> LDA -> LDB -> CHECK -> SUB* -> DONE and emits the
// datapath strobes; busy/done are registered alongside the state.
module div_control_path
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqz,      // divisor register is zero
  input  logic alb,      // A < B
  input  logic nlt,      // (A - B) < B: this subtraction is the last one
  output logic lda,      // load dividend into A
  output logic ldb,      // load divisor into B, clear Q/flags/counter
  output logic ldq,      // force Q to all ones (divide by zero)
  output logic incq,     // Q <= Q + 1
  output logic subr,     // A <= A - B
  output logic set_dbz,  // raise divide-by-zero flag
  output logic busy,
  output logic done
);

  state_t state_reg;

  // State register with busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LDA;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        LDA: begin
          state_reg <= LDB;
        end
        LDB: begin
          state_reg <= CHECK;
        end
        CHECK: begin
          if (eqz || alb) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= SUB;
          end
        end
        SUB: begin
          if (nlt) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_reg <= LDA;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes decoded from the current state and datapath status
  always_comb begin
    lda     = 1'b0;
    ldb     = 1'b0;
    ldq     = 1'b0;
    incq    = 1'b0;
    subr    = 1'b0;
    set_dbz = 1'b0;
    case (state_reg)
      LDA:   lda = 1'b1;
      LDB:   ldb = 1'b1;
      CHECK: begin
        ldq     = eqz;
        set_dbz = eqz;
      end
      SUB: begin
        subr = 1'b1;
        incq = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/repeated_sub_divider.sv
// Sequential unsigned divider by repeated subtraction.
// Operands arrive serially on the shared data bus (dividend, then divisor);
// the A register becomes the remainder and Q the quotient.
// Optional feature macro: DIV_CYCLE_COUNT_EN adds a SUB-cycle counter on cycle_cnt.
module repeated_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  repeated_sub_divider_if.slave bus
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] diff;

  logic eqz, alb, nlt;
  logic lda, ldb, ldq, incq, subr, set_dbz;
  logic busy, done;

  // Subtraction is only committed when A >= B, so diff never wraps when used
  assign diff = a_reg - b_reg;
  assign eqz  = (b_reg == '0);
  assign alb  = (a_reg < b_reg);
  assign nlt  = (diff < b_reg);

  div_control_path u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .eqz     (eqz),
    .alb     (alb),
    .nlt     (nlt),
    .lda     (lda),
    .ldb     (ldb),
    .ldq     (ldq),
    .incq    (incq),
    .subr    (subr),
    .set_dbz (set_dbz),
    .busy    (busy),
    .done    (done)
  );

  // Operand, quotient and flag registers driven by the control strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      q_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      if (lda) begin
        a_reg <= bus.data;
      end
      if (ldb) begin
        b_reg   <= bus.data;
        q_reg   <= '0;
        dbz_reg <= 1'b0;
      end
      if (subr) begin
        a_reg <= diff;
      end
      if (incq) begin
        q_reg <= q_reg + 1'b1;
      end
      if (ldq) begin
        q_reg <= '1;
      end
      if (set_dbz) begin
        dbz_reg <= 1'b1;
      end
    end
  end

`ifdef DIV_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cnt_reg;

  // SUB-cycle counter: cleared with the divisor load, held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (ldb) begin
      cnt_reg <= '0;
    end else if (subr) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.cycle_cnt = cnt_reg;
`endif

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz_reg;
  assign bus.quotient    = q_reg;
  assign bus.remainder   = a_reg;

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Directed testbench for repeated_sub_divider: hand-computed quotient,
// remainder, flag and latency values for each operation.
module tb_repeated_sub_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  repeated_sub_divider_if #(.WIDTH(16)) bus ();

  repeated_sub_divider #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one operation starting from IDLE/DONE and wait (bounded) for done.
  // cycles counts rising edges from the start-sampling edge to done.
  task automatic do_op(input logic [15:0] dvd, input logic [15:0] dvs,
                       input bit hold, output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    bus.start = 1'b1;
    bus.data = dvd;
    @(posedge clk); cycles++; #1;
    if (!hold) bus.start = 1'b0;
    @(posedge clk); cycles++; #1;
    bus.data = dvs;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); cycles++; #1;
      bus.data = 16'hA5A5;
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
    end
    $display("op %0d / %0d: cycles=%0d q=%0d r=%0d dbz=%0b", dvd, dvs, cycles,
             bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.div_by_zero});
    end
    total++;
    if ({bus.quotient, bus.remainder} !== 32'h0) begin
      bad++; $display("FAIL reset_results got=%h exp=0", {bus.quotient, bus.remainder});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_start got busy=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int cyc; bit to;
    do_op(16'd17, 16'd5, 1'b0, cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got done=0 exp=1"); end
    total++;
    if (cyc !== 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", cyc); end
    total++;
    if (bus.quotient !== 16'd3) begin bad++; $display("FAIL basic_q got=%0d exp=3", bus.quotient); end
    total++;
    if (bus.remainder !== 16'd2) begin bad++; $display("FAIL basic_r got=%0d exp=2", bus.remainder); end
    total++;
    if ({bus.div_by_zero, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL basic_flags got=%b exp=00", {bus.div_by_zero, bus.busy});
    end
`ifdef DIV_CYCLE_COUNT_EN
    total++;
    if (bus.cycle_cnt !== 16'd3) begin bad++; $display("FAIL basic_cnt got=%0d exp=3", bus.cycle_cnt); end
`endif
  endtask

  task automatic test_hold_done();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 16'd3, 16'd2}) begin
      bad++; $display("FAIL done_hold got done=%b q=%0d r=%0d exp done=1 q=3 r=2",
                      bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_a_less_b();
    int cyc; bit to;
    do_op(16'd5, 16'd17, 1'b0, cyc, to);
    total++;
    if (to || cyc !== 4) begin bad++; $display("FAIL altb_latency got=%0d exp=4", cyc); end
    total++;
    if ({bus.quotient, bus.remainder} !== {16'd0, 16'd5}) begin
      bad++; $display("FAIL altb_qr got q=%0d r=%0d exp q=0 r=5", bus.quotient, bus.remainder);
    end
    total++;
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL altb_dbz got=%b exp=0", bus.div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int cyc; bit to;
    do_op(16'd10, 16'd0, 1'b0, cyc, to);
    total++;
    if (to || cyc !== 4) begin bad++; $display("FAIL dbz_latency got=%0d exp=4", cyc); end
    total++;
    if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
    total++;
    if (bus.quotient !== 16'hFFFF) begin bad++; $display("FAIL dbz_q got=%h exp=ffff", bus.quotient); end
    total++;
    if (bus.remainder !== 16'd10) begin bad++; $display("FAIL dbz_r got=%0d exp=10", bus.remainder); end
`ifdef DIV_CYCLE_COUNT_EN
    total++;
    if (bus.cycle_cnt !== 16'd0) begin bad++; $display("FAIL dbz_cnt got=%0d exp=0", bus.cycle_cnt); end
`endif
  endtask

  task automatic test_max();
    int cyc; bit to;
    do_op(16'd65535, 16'd1, 1'b0, cyc, to);
    total++;
    if (to || cyc !== 65539) begin bad++; $display("FAIL max_latency got=%0d exp=65539", cyc); end
    total++;
    if ({bus.quotient, bus.remainder} !== {16'd65535, 16'd0}) begin
      bad++; $display("FAIL max_qr got q=%0d r=%0d exp q=65535 r=0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit to;
    bus.start = 1'b1;
    bus.data = 16'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.data = 16'd3;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL midop_busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'h0) begin
      bad++; $display("FAIL midop_reset got busy=%b done=%b q=%0d r=%0d exp all 0",
                      bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    $display("reset during 100 / 3 applied");
    do_op(16'd100, 16'd3, 1'b0, cyc, to);
    total++;
    if (to || cyc !== 37) begin bad++; $display("FAIL fresh_latency got=%0d exp=37", cyc); end
    total++;
    if ({bus.quotient, bus.remainder} !== {16'd33, 16'd1}) begin
      bad++; $display("FAIL fresh_qr got q=%0d r=%0d exp q=33 r=1", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_rst_start();
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL rst_wins got busy=%b done=%b exp 00", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle got busy=%b exp=0", bus.busy); end
    $display("simultaneous rst/start: busy=%b", bus.busy);
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    do_op(16'd9, 16'd2, 1'b1, cyc, to);
    total++;
    if (to || cyc !== 8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=8", cyc); end
    total++;
    if ({bus.quotient, bus.remainder} !== {16'd4, 16'd1}) begin
      bad++; $display("FAIL b2b_first_qr got q=%0d r=%0d exp q=4 r=1", bus.quotient, bus.remainder);
    end
    // start still high in DONE: next edge enters LDA with the new dividend
    bus.data = 16'd40;
    @(posedge clk); #1;
    total++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      bad++; $display("FAIL b2b_done_drop got done=%b busy=%b exp done=0 busy=1", bus.done, bus.busy);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.data = 16'd8;
    cyc = 2;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); cyc++; #1;
      bus.data = 16'h5A5A;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
    $display("op 40 / 8: cycles=%0d q=%0d r=%0d", cyc, bus.quotient, bus.remainder);
    total++;
    if (to || cyc !== 9) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=9", cyc); end
    total++;
    if ({bus.quotient, bus.remainder} !== {16'd5, 16'd0}) begin
      bad++; $display("FAIL b2b_second_qr got q=%0d r=%0d exp q=5 r=0", bus.quotient, bus.remainder);
    end
`ifdef DIV_CYCLE_COUNT_EN
    total++;
    if (bus.cycle_cnt !== 16'd5) begin bad++; $display("FAIL b2b_cnt got=%0d exp=5", bus.cycle_cnt); end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data = 16'h0;
    test_reset();
    test_basic();
    test_hold_done();
    test_a_less_b();
    test_div_by_zero();
    test_max();
    test_reset_mid_op();
    test_rst_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
